axi_4_slave_mem_datapath: RTL and testbench
===========================================

Name: axi_4_slave_mem_datapath

Overview:
Memory-side datapath that sits directly downstream of the AXI4 slave controller FSM.
- Captures read and write burst address and control on the address handshakes.
- Generates per-beat addresses (FIXED/INCR/WRAP) and holds a word-addressed memory array.
- Returns data_fetched, data_stored, s_rlast and wlast_done to the controller, and drives the R/B channel payloads to the master.

Parameters:
ADDR_W, 32, byte-address width
DATA_W, 32, data beat width; byte lanes = DATA_W/8
MEM_DEPTH, 1024, number of DATA_W words in the array
RD_LAT, 1, cycles from beat address valid to data_fetched (1..4)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
m_araddr  in  ADDR_W  read start byte address
m_arlen  in  8  read beats minus 1
m_arburst  in  2  read burst type
m_arvalid  in  1  read address valid
s_arready  in  1  controller's arready (handshake qualifier)
m_awaddr  in  ADDR_W  write start byte address
m_awlen  in  8  write beats minus 1
m_awburst  in  2  write burst type
m_awvalid  in  1  write address valid
s_awready  in  1  controller's awready
m_wdata  in  DATA_W  write data
m_wstrb  in  DATA_W/8  byte strobes
m_wlast  in  1  master last-beat flag
s_rvalid  in  1  controller's rvalid
m_rready  in  1  master read ready
incre_counter  in  1  advance to next beat (from controller)
store_data  in  1  commit current write beat (from controller)
data_fetched  out  1  current read beat data valid on s_rdata
data_stored  out  1  current write beat committed
s_rlast  out  1  current read beat is last
wlast_done  out  1  committed write beat was last
s_rdata  out  DATA_W  read data
s_rresp  out  2  read response
s_bresp  out  2  write response

Behaviour:
- Reset: all outputs 0; beat counters, address registers and error flags cleared. Memory contents are not reset. Reset mid-burst aborts the burst; no partial-state carry-over.
- Capture:
  - Read context (addr, len, burst) loads on m_arvalid && s_arready.
  - Write context loads on m_awvalid && s_awready.
  - The two contexts are independent registers; both may capture in the same cycle.
  - Each capture zeroes its beat counter and its error flag.
- Word address = byte address >> log2(DATA_W/8). Beat address evolves per burst type:
  - FIXED: held.
  - INCR: +DATA_W/8 per beat.
  - WRAP: wraps within an aligned (len+1)*bytes window.
- Read path:
  - RD_LAT cycles after capture, or after incre_counter, s_rdata is loaded and data_fetched rises.
  - data_fetched holds until incre_counter or until s_rvalid && m_rready && s_rlast; it then clears the next cycle.
  - s_rlast = (rd_beat_cnt == arlen), combinational from the counter.
  - incre_counter increments rd_beat_cnt and advances the address.
- Write path:
  - When store_data=1 and the beat is not yet committed, m_wdata is written under m_wstrb. data_stored pulses high for exactly 1 cycle the following cycle.
  - A per-beat commit flag blocks double writes if store_data is held; the flag clears on incre_counter.
  - wlast_done = data_stored && (wr_beat_cnt == awlen).
  - m_wlast disagreeing with the counter sets the write error flag.
- Responses, OKAY=2'b00, SLVERR=2'b10:
  - A beat word address >= MEM_DEPTH gives SLVERR; reads of it return 0 and writes to it are dropped.
  - WRAP with len not in {1,3,7,15} gives SLVERR and is executed as INCR.
  - s_rresp is per beat.
  - s_bresp is sticky across the burst, valid with wlast_done, and cleared on the next aw capture.
- Boundary cases:
  - arlen=0: s_rlast=1 on the first beat.
  - INCR past the array end: remaining beats error; no wrap to 0.
  - incre_counter arriving together with a new capture: the capture wins.

Optional Feature:
AXI4_SLV_WRAP_EN
- Defined: WRAP bursts are supported as above.
- Undefined: burst type 2'b10 is executed as INCR with SLVERR on every beat, and the wrap-mask logic is not compiled.
- Reserved burst type 2'b11 always gives SLVERR and executes as INCR.

Decomposition:
- axi_4_pkg holds:
  - axi_burst_e (FIXED=0, INCR=1, WRAP=2, RSVD=3)
  - AXI_RESP_OKAY / AXI_RESP_SLVERR constants
  - burst-context struct (addr, len, burst, err)
- Sub-module axi_4_burst_addr_gen: combinational next-address and wrap-boundary calculation from (addr, len, burst, size). It is instantiated once for read and once for write.

Test Plan:
- INCR read, araddr=0x10, arlen=3, mem[4..7]=A..D, RD_LAT=1 -> four beats A,B,C,D; s_rlast only on D; s_rresp=0 on every beat.
- INCR write, awaddr=0x0, awlen=1, wdata=0x11223344 then 0x55667788, wstrb=4'b0011 on beat 2 -> mem[0]=0x11223344, mem[1]=0xXXXX7788 (upper lanes unchanged); wlast_done on beat 2; s_bresp=0.
- WRAP read, araddr=0x18, arlen=3 with AXI4_SLV_WRAP_EN -> words 6,7,4,5; without the macro -> words 6,7,8,9 with SLVERR on every beat.
- store_data held 3 cycles on one beat -> exactly one memory write; data_stored high for exactly 1 cycle.
- Read at word MEM_DEPTH-1, arlen=1 -> beat 1 OKAY; beat 2 returns 0 with SLVERR.
- reset asserted during beat 2 of a 4-beat read -> outputs 0 next edge; a fresh read of arlen=0 then completes normally.

Source files
------------

// File: rtl/axi_4_pkg.sv
// Shared types for the AXI4 slave memory datapath.
// Define AXI4_SLV_WRAP_EN to support WRAP bursts.
package axi_4_pkg;

    // Internal byte-address width; wide enough that INCR never wraps to 0.
    localparam int AXI_AW = 64;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2,
        RSVD  = 2'd3
    } axi_burst_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [AXI_AW-1:0] addr;
        logic [7:0]        len;
        axi_burst_e        burst;
        logic              err;
    } axi_ctx_t;

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) ||
               (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_4_burst_addr_gen.sv
// Next beat address and burst legality for one burst context.
// WRAP windowing is only built with AXI4_SLV_WRAP_EN.
module axi_4_burst_addr_gen
    import axi_4_pkg::*;
(
    input  logic [AXI_AW-1:0] addr,
`ifdef AXI4_SLV_WRAP_EN
    input  logic [7:0]        len,
`endif
    input  axi_burst_e        burst,
    input  logic [2:0]        size,
    output logic [AXI_AW-1:0] next_addr,
    output logic              err
);

    logic [AXI_AW-1:0] incr;

    assign incr = addr + (AXI_AW'(1) << size);

`ifdef AXI4_SLV_WRAP_EN
    logic              len_ok;
    logic              use_wrap;
    logic [AXI_AW-1:0] mask;

    assign len_ok   = wrap_len_ok(len);
    assign use_wrap = (burst == WRAP) && len_ok;
    assign mask     = ((AXI_AW'(len) + AXI_AW'(1)) << size) - AXI_AW'(1);
    assign err      = (burst == RSVD) || ((burst == WRAP) && !len_ok);

    always_comb begin
        next_addr = incr;
        if (burst == FIXED)
            next_addr = addr;
        else if (use_wrap)
            next_addr = (addr & ~mask) | (incr & mask);
    end
`else
    // Without wrap support both WRAP and RSVD run as INCR and error.
    assign err       = (burst == WRAP) || (burst == RSVD);
    assign next_addr = (burst == FIXED) ? addr : incr;
`endif

endmodule

// File: rtl/axi_4_slave_mem_datapath.sv
// Memory-side datapath behind the AXI4 slave controller FSM.
// Optional WRAP support via AXI4_SLV_WRAP_EN.
module axi_4_slave_mem_datapath
    import axi_4_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 1024,
    parameter int RD_LAT    = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m_araddr,
    input  logic [7:0]          m_arlen,
    input  logic [1:0]          m_arburst,
    input  logic                m_arvalid,
    input  logic                s_arready,
    input  logic [ADDR_W-1:0]   m_awaddr,
    input  logic [7:0]          m_awlen,
    input  logic [1:0]          m_awburst,
    input  logic                m_awvalid,
    input  logic                s_awready,
    input  logic [DATA_W-1:0]   m_wdata,
    input  logic [DATA_W/8-1:0] m_wstrb,
    input  logic                m_wlast,
    input  logic                s_rvalid,
    input  logic                m_rready,
    input  logic                incre_counter,
    input  logic                store_data,
    output logic                data_fetched,
    output logic                data_stored,
    output logic                s_rlast,
    output logic                wlast_done,
    output logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          s_rresp,
    output logic [1:0]          s_bresp
);

    localparam int NB = DATA_W / 8;
    localparam int SZ = $clog2(NB);
    localparam int IW = $clog2(MEM_DEPTH);
    localparam logic [2:0] LAT = 3'(RD_LAT);
    localparam logic [AXI_AW-1:0] DEPTH = AXI_AW'(MEM_DEPTH);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    axi_ctx_t          rd_ctx, wr_ctx;
    logic [7:0]        rd_cnt, wr_cnt;
    logic [2:0]        rd_wait;
    logic              rd_active, wr_done;
    logic [AXI_AW-1:0] rd_next, wr_next, rd_word, wr_word;
    logic              rd_gerr, wr_gerr, rd_oor, wr_oor;
    logic              rd_cap, wr_cap, rd_adv, rd_end;
    logic              commit, wr_last;

    axi_4_burst_addr_gen u_rd_gen (
        .addr      (rd_ctx.addr),
`ifdef AXI4_SLV_WRAP_EN
        .len       (rd_ctx.len),
`endif
        .burst     (rd_ctx.burst),
        .size      (3'(SZ)),
        .next_addr (rd_next),
        .err       (rd_gerr)
    );

    axi_4_burst_addr_gen u_wr_gen (
        .addr      (wr_ctx.addr),
`ifdef AXI4_SLV_WRAP_EN
        .len       (wr_ctx.len),
`endif
        .burst     (wr_ctx.burst),
        .size      (3'(SZ)),
        .next_addr (wr_next),
        .err       (wr_gerr)
    );

    assign rd_cap  = m_arvalid && s_arready;
    assign wr_cap  = m_awvalid && s_awready;
    assign rd_word = rd_ctx.addr >> SZ;
    assign wr_word = wr_ctx.addr >> SZ;
    assign rd_oor  = rd_word >= DEPTH;
    assign wr_oor  = wr_word >= DEPTH;

    assign s_rlast = rd_active && (rd_cnt == rd_ctx.len);
    assign rd_adv  = incre_counter && data_fetched && !s_rlast;
    assign rd_end  = data_fetched &&
                     (incre_counter || (s_rvalid && m_rready && s_rlast));
    assign s_rresp = rd_ctx.err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;

    assign wr_last    = wr_cnt == wr_ctx.len;
    assign commit     = store_data && !wr_done && !wr_cap;
    assign wlast_done = data_stored && wr_last;
    assign s_bresp    = wr_ctx.err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;

    // Read side; rd_ctx.err carries the response of the beat on s_rdata.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ctx       <= '0;
            rd_cnt       <= '0;
            rd_wait      <= '0;
            rd_active    <= 1'b0;
            data_fetched <= 1'b0;
            s_rdata      <= '0;
        end else if (rd_cap) begin
            rd_ctx <= '{addr: AXI_AW'(m_araddr), len: m_arlen,
                        burst: axi_burst_e'(m_arburst), err: 1'b0};
            rd_cnt       <= '0;
            rd_wait      <= LAT;
            rd_active    <= 1'b1;
            data_fetched <= 1'b0;
        end else if (rd_adv) begin
            rd_ctx.addr  <= rd_next;
            rd_cnt       <= rd_cnt + 8'd1;
            rd_wait      <= LAT;
            data_fetched <= 1'b0;
        end else if (rd_wait != 3'd0) begin
            rd_wait <= rd_wait - 3'd1;
            if (rd_wait == 3'd1) begin
                data_fetched <= 1'b1;
                s_rdata      <= rd_oor ? '0 : mem[rd_word[IW-1:0]];
                rd_ctx.err   <= rd_gerr || rd_oor;
            end
        end else if (rd_end) begin
            data_fetched <= 1'b0;
            if (s_rlast)
                rd_active <= 1'b0;
        end
    end

    // Write side; wr_ctx.err is the sticky burst response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ctx      <= '0;
            wr_cnt      <= '0;
            wr_done     <= 1'b0;
            data_stored <= 1'b0;
        end else begin
            data_stored <= commit;
            if (wr_cap) begin
                wr_ctx <= '{addr: AXI_AW'(m_awaddr), len: m_awlen,
                            burst: axi_burst_e'(m_awburst), err: 1'b0};
                wr_cnt  <= '0;
                wr_done <= 1'b0;
            end else if (commit) begin
                wr_done    <= 1'b1;
                wr_ctx.err <= wr_ctx.err || wr_gerr || wr_oor ||
                              (m_wlast != wr_last);
            end else if (incre_counter && wr_done) begin
                wr_done <= 1'b0;
                if (!wr_last) begin
                    wr_cnt      <= wr_cnt + 8'd1;
                    wr_ctx.addr <= wr_next;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit && !wr_oor) begin
            for (int i = 0; i < NB; i++) begin
                if (m_wstrb[i])
                    mem[wr_word[IW-1:0]][8*i +: 8] <= m_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_4_slave_mem_datapath.sv
// Randomized self-checking bench for axi_4_slave_mem_datapath.
// Expectations follow AXI4_SLV_WRAP_EN when it is defined.
module tb_axi_4_slave_mem_datapath;

    localparam int DEPTH  = 1024;
    localparam int RD_LAT = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m_araddr, m_awaddr, m_wdata, s_rdata;
    logic [7:0]  m_arlen, m_awlen;
    logic [1:0]  m_arburst, m_awburst, s_rresp, s_bresp;
    logic [3:0]  m_wstrb;
    logic        m_arvalid, s_arready, m_awvalid, s_awready, m_wlast;
    logic        s_rvalid, m_rready, incre_counter, store_data;
    logic        data_fetched, data_stored, s_rlast, wlast_done;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];
    int          bad_wlast_beat = -1;

    axi_4_slave_mem_datapath #(
        .ADDR_W(32), .DATA_W(32), .MEM_DEPTH(DEPTH), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arburst(m_arburst),
        .m_arvalid(m_arvalid), .s_arready(s_arready),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awburst(m_awburst),
        .m_awvalid(m_awvalid), .s_awready(s_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .s_rvalid(s_rvalid), .m_rready(m_rready),
        .incre_counter(incre_counter), .store_data(store_data),
        .data_fetched(data_fetched), .data_stored(data_stored),
        .s_rlast(s_rlast), .wlast_done(wlast_done),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_bresp(s_bresp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit burst_err(input int burst, input int len);
        bit lok = (len == 1) || (len == 3) || (len == 7) || (len == 15);
        if (burst == 3) return 1'b1;
`ifdef AXI4_SLV_WRAP_EN
        if (burst == 2) return !lok;
`else
        if (burst == 2) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic longint beat_addr(input longint start, input int len,
                                         input int burst, input int b);
        longint w, base;
        if (burst == 0) return start;
`ifdef AXI4_SLV_WRAP_EN
        if (burst == 2 && !burst_err(burst, len)) begin
            w    = longint'(len + 1) * 4;
            base = (start / w) * w;
            return base + ((start - base) + longint'(b) * 4) % w;
        end
`endif
        w = 0;
        base = 0;
        return start + longint'(b) * 4 + w + base;
    endfunction

    task automatic rand_data(input int len);
        for (int i = 0; i <= len; i++) begin
            wd[i] = $urandom;
            ws[i] = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_df"}, data_fetched, 0);
        check({tag, "_ds"}, data_stored, 0);
        check({tag, "_rlast"}, s_rlast, 0);
        check({tag, "_wld"}, wlast_done, 0);
        check({tag, "_rdata"}, s_rdata, 0);
        check({tag, "_rresp"}, s_rresp, 0);
        check({tag, "_bresp"}, s_bresp, 0);
    endtask

    task automatic wr_burst(input longint addr, input int len,
                            input int burst, input int hold);
        bit     eerr, oor;
        longint a;
        int     w;
        eerr = burst_err(burst, len);
        @(negedge clk);
        m_awaddr = 32'(addr); m_awlen = 8'(len); m_awburst = 2'(burst);
        m_awvalid = 1; s_awready = 1;
        @(negedge clk);
        m_awvalid = 0; s_awready = 0;
        check("bresp_clr", s_bresp, 0);
        for (int b = 0; b <= len; b++) begin
            a   = beat_addr(addr, len, burst, b);
            oor = (a / 4) >= DEPTH;
            w   = int'(a / 4);
            m_wdata = wd[b]; m_wstrb = ws[b];
            m_wlast = (b == len) ^ (b == bad_wlast_beat);
            if (oor || (b == bad_wlast_beat)) eerr = 1;
            if (!oor)
                for (int i = 0; i < 4; i++)
                    if (ws[b][i]) ref_mem[w][8*i +: 8] = wd[b][8*i +: 8];
            store_data = 1;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                m_wdata = ~wd[b];
                if (h == hold - 1) store_data = 0;
                check("stored", data_stored, h == 0);
                if (h == 0) begin
                    check("wlast_done", wlast_done, b == len);
                    if (b == len) check("bresp", s_bresp, eerr ? 2 : 0);
                end
            end
            @(negedge clk);
            check("stored_pulse", data_stored, 0);
            incre_counter = 1;
            @(negedge clk);
            incre_counter = 0;
        end
    endtask

    task automatic rd_burst(input longint addr, input int len, input int burst);
        bit     oor, eerr;
        longint a;
        int     lat;
        @(negedge clk);
        m_araddr = 32'(addr); m_arlen = 8'(len); m_arburst = 2'(burst);
        m_arvalid = 1; s_arready = 1;
        @(negedge clk);
        m_arvalid = 0; s_arready = 0;
        for (int b = 0; b <= len; b++) begin
            lat = 0;
            while (!data_fetched && lat < 12) begin
                @(negedge clk);
                lat++;
            end
            check("rd_lat", lat, RD_LAT);
            a    = beat_addr(addr, len, burst, b);
            oor  = (a / 4) >= DEPTH;
            eerr = burst_err(burst, len) || oor;
            check("rdata", s_rdata, oor ? 0 : ref_mem[int'(a / 4)]);
            check("rresp", s_rresp, eerr ? 2 : 0);
            check("rlast", s_rlast, b == len);
            if (b < len) begin
                incre_counter = 1;
                @(negedge clk);
                incre_counter = 0;
                check("df_clr", data_fetched, 0);
            end else begin
                s_rvalid = 1; m_rready = 1;
                @(negedge clk);
                s_rvalid = 0; m_rready = 0;
                check("df_end", data_fetched, 0);
                check("rlast_end", s_rlast, 0);
            end
        end
    endtask

    initial begin
        int lat, len, burst;
        longint addr;
        reset = 0;
        {m_araddr, m_arlen, m_arburst, m_arvalid, s_arready} = '0;
        {m_awaddr, m_awlen, m_awburst, m_awvalid, s_awready} = '0;
        {m_wdata, m_wstrb, m_wlast, s_rvalid, m_rready} = '0;
        incre_counter = 0; store_data = 0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        reset = 1;

        for (int k = 0; k < 4; k++) begin
            rand_data(255);
            for (int i = 0; i < 256; i++) ws[i] = 4'hF;
            wr_burst(longint'(k) * 1024, 255, 1, 1);
        end

        wd[0] = 32'h11223344; ws[0] = 4'hF;
        wd[1] = 32'h55667788; ws[1] = 4'b0011;
        wr_burst(0, 1, 1, 1);
        rd_burst(0, 1, 1);
        rd_burst(32'h10, 3, 1);
        rd_burst(32'h18, 3, 2);

        rand_data(0);
        wr_burst(32'h40, 0, 1, 3);
        rd_burst(32'h40, 0, 1);

        rd_burst((DEPTH - 1) * 4, 1, 1);
        rand_data(3);
        wr_burst((DEPTH - 2) * 4, 3, 1, 1);
        rd_burst((DEPTH - 2) * 4, 3, 1);

        rand_data(3);
        wr_burst(32'h104, 3, 2, 1);
        rd_burst(32'h100, 3, 1);
        rand_data(2);
        wr_burst(32'h200, 2, 0, 1);
        rd_burst(32'h200, 0, 1);
        rand_data(2);
        bad_wlast_beat = 1;
        wr_burst(32'h300, 2, 1, 1);
        bad_wlast_beat = -1;
        rd_burst(32'h300, 2, 1);

        for (int t = 0; t < 40; t++) begin
            burst = $urandom_range(0, 3);
            len   = $urandom_range(0, 15);
            if (burst == 2 && $urandom_range(0, 3) != 0)
                len = (1 << $urandom_range(1, 4)) - 1;
            addr = longint'($urandom_range(0, DEPTH + 16)) * 4;
            if ($urandom_range(0, 1) == 1) begin
                rand_data(len);
                wr_burst(addr, len, burst, $urandom_range(1, 2));
            end else begin
                rd_burst(addr, len, burst);
            end
        end

        @(negedge clk);
        m_araddr = 32'h80; m_arlen = 8'd3; m_arburst = 2'd1;
        m_arvalid = 1; s_arready = 1;
        @(negedge clk);
        m_arvalid = 0; s_arready = 0;
        for (int b = 0; b < 2; b++) begin
            lat = 0;
            while (!data_fetched && lat < 12) begin
                @(negedge clk);
                lat++;
            end
            check("mid_lat", lat, RD_LAT);
            if (b == 0) begin
                incre_counter = 1;
                @(negedge clk);
                incre_counter = 0;
            end
        end
        check("mid_beat2", s_rdata, ref_mem[33]);
        #2 reset = 0;
        @(posedge clk);
        #1 check_idle("mid_reset");
        @(negedge clk);
        reset = 1;
        rd_burst(32'h44, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
